mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one sequential shift-add multiplier (8-iteration unit, pulse-start/pulse-done interface) among N_REQ requesters. It accepts one operand pair at a time through a per-requester valid/ready handshake and launches the multiplier. It waits for completion under a watchdog and returns the product to the granted requester. It sits between the requesting datapath blocks and the multiplier's control unit.

---
 rtl/mult_arbiter.sv | 160 ++++++++++++++++
 tb/tb_mult_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one pulse-start/pulse-done multiplier
// among N_REQ requesters, with a watchdog on the BUSY wait.
module mult_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  output logic [N_REQ-1:0]       req_ready,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [2*WIDTH-1:0]     resp_product,
  output logic                   resp_err,
  output logic                   busy,
  output logic                   mult_valid,
  output logic [WIDTH-1:0]       mult_a,
  output logic [WIDTH-1:0]       mult_b,
  input  logic                   mult_done,
  input  logic [2*WIDTH-1:0]     mult_product
);
  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {
    IDLE, LAUNCH, BUSY, RESPOND
  } state_e;

  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] id_q, id_d;
  logic [TW-1:0] wdog_q, wdog_d;

  logic [N_REQ-1:0]   resp_valid_q, resp_valid_d;
  logic [2*WIDTH-1:0] resp_product_q, resp_product_d;
  logic               resp_err_q, resp_err_d;
  logic               busy_q, busy_d;
  logic               mult_valid_q, mult_valid_d;
  logic [WIDTH-1:0]   mult_a_q, mult_a_d;
  logic [WIDTH-1:0]   mult_b_q, mult_b_d;

  logic [IW-1:0] grant;
  logic          hs;

  function automatic logic [IW-1:0] rr_idx(
    input logic [IW-1:0] ptr,
    input int            k
  );
    int s;
    s = int'(ptr) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return s[IW-1:0];
  endfunction

  // Scan downwards so the requester closest to ptr wins.
  always_comb begin
    grant = ptr_q;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[rr_idx(ptr_q, k)]) grant = rr_idx(ptr_q, k);
    end
  end

  assign hs = (state_q == IDLE) && (|req_valid) && !rst;

  always_comb begin
    req_ready = '0;
    if (hs) req_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wdog_d  = wdog_q;
    unique case (state_q)
      IDLE: begin
        if (hs) state_d = LAUNCH;
      end
      LAUNCH: begin
        state_d = BUSY;
        wdog_d  = '0;
      end
      BUSY: begin
        if (mult_done || wdog_q == TW'(TIMEOUT)) state_d = RESPOND;
        else wdog_d = wdog_q + 1'b1;
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs are computed from the next state.
  always_comb begin
    id_d           = id_q;
    ptr_d          = ptr_q;
    mult_a_d       = mult_a_q;
    mult_b_d       = mult_b_q;
    resp_product_d = resp_product_q;
    resp_err_d     = resp_err_q;
    resp_valid_d   = '0;
    mult_valid_d   = (state_d == LAUNCH);
    busy_d         = (state_d != IDLE);
    if (hs) begin
      id_d     = grant;
      mult_a_d = req_a[grant*WIDTH +: WIDTH];
      mult_b_d = req_b[grant*WIDTH +: WIDTH];
    end
    if (state_q == BUSY && state_d == RESPOND) begin
      resp_product_d       = mult_done ? mult_product : '0;
      resp_err_d           = !mult_done;
      resp_valid_d[id_q]   = 1'b1;
    end
    if (state_q == RESPOND) begin
      ptr_d = (int'(id_q) == N_REQ - 1) ? '0 : id_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q          <= '0;
      id_q           <= '0;
      resp_valid_q   <= '0;
      resp_product_q <= '0;
      resp_err_q     <= 1'b0;
      busy_q         <= 1'b0;
      mult_valid_q   <= 1'b0;
      mult_a_q       <= '0;
      mult_b_q       <= '0;
    end else begin
      ptr_q          <= ptr_d;
      id_q           <= id_d;
      resp_valid_q   <= resp_valid_d;
      resp_product_q <= resp_product_d;
      resp_err_q     <= resp_err_d;
      busy_q         <= busy_d;
      mult_valid_q   <= mult_valid_d;
      mult_a_q       <= mult_a_d;
      mult_b_q       <= mult_b_d;
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_product = resp_product_q;
  assign resp_err     = resp_err_q;
  assign busy         = busy_q;
  assign mult_valid   = mult_valid_q;
  assign mult_a       = mult_a_q;
  assign mult_b       = mult_b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: random requesters and a latency-programmable multiplier
// stub, checked against a transaction-timeline model.
module tb_mult_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready, resp_valid;
  logic [2*W-1:0] resp_product, mult_product;
  logic           resp_err, busy, mult_valid, mult_done;
  logic [W-1:0]   mult_a, mult_b;

  always #5 clk = ~clk;

  mult_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_product(resp_product), .resp_err(resp_err),
    .busy(busy), .mult_valid(mult_valid),
    .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .mult_product(mult_product)
  );

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  // requesters
  logic         vr [N];
  logic [W-1:0] ar [N];
  logic [W-1:0] br [N];
  logic [N-1:0] mask = '0;
  int           p_raise = 0;
  logic         rst_req = 1'b1;

  // timeline model
  int             rr = 0, next_free = 0, hs_id = -1;
  bit             op_on = 0, op_err = 0;
  int             op_id = 0, launch_c = -1, resp_c = -1;
  int             done_c = -1, late_c = -1, lat_fix = 9;
  logic [2*W-1:0] stub_prod = '0, h_prod = '0;
  logic           h_err = 1'b0;
  logic [W-1:0]   h_a = '0, h_b = '0;

  // observations
  int             glog[$];
  int             hlog[$];
  int             hs_seen = 0, resp_cnt = 0, last_resp_c = 0;
  logic [N-1:0]   last_vec = '0;
  logic [2*W-1:0] last_prod = '0;
  logic           last_err = 1'b0;

  function automatic int exp_grant();
    for (int k = 0; k < N; k++) if (vr[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  function automatic bit any_vr();
    for (int i = 0; i < N; i++) if (vr[i]) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    rr = 0; next_free = 0; op_on = 0; late_c = -1; done_c = -1;
    h_prod = '0; h_err = 1'b0; h_a = '0; h_b = '0;
  endtask

  task automatic model_hs(input int id);
    int d;
    if (lat_fix != 0) d = lat_fix;
    else begin
      case ($urandom_range(0, 9))
        8: d = 9;
        9: d = $urandom_range(TO + 2, TO + 4);
        default: d = $urandom_range(1, TO + 1);
      endcase
    end
    op_on = 1; op_id = id; launch_c = cyc;
    stub_prod = ar[id] * br[id];
    h_a = ar[id]; h_b = br[id];
    vr[id] = 1'b0;
    rr = (id + 1) % N;
    if (d <= TO + 1) begin
      done_c = launch_c + d; resp_c = launch_c + d + 1; op_err = 0;
    end else begin
      done_c = -1; resp_c = launch_c + TO + 2; op_err = 1;
      late_c = (d < 100) ? launch_c + d : -1;
    end
    next_free = resp_c + 1;
  endtask

  task automatic check_regs();
    logic [N-1:0] ev;
    ev = '0;
    if (op_on && cyc == resp_c) begin
      ev[op_id] = 1'b1;
      h_prod = op_err ? '0 : stub_prod;
      h_err = op_err;
    end
    check("mult_valid", mult_valid, op_on && cyc == launch_c);
    check("mult_a", mult_a, h_a);
    check("mult_b", mult_b, h_b);
    check("busy", busy, op_on && cyc >= launch_c && cyc <= resp_c);
    check("resp_valid", resp_valid, ev);
    check("resp_product", resp_product, h_prod);
    check("resp_err", resp_err, h_err);
    if (resp_valid != '0) begin
      resp_cnt++; last_resp_c = cyc; last_vec = resp_valid;
      last_prod = resp_product; last_err = resp_err;
    end
  endtask

  task automatic drive();
    rst = rst_req;
    for (int i = 0; i < N; i++) begin
      if (!vr[i] && mask[i] && $urandom_range(0, 99) < p_raise) begin
        vr[i] = 1'b1; ar[i] = W'($urandom); br[i] = W'($urandom);
      end
      req_valid[i] = vr[i];
      req_a[i*W +: W] = ar[i];
      req_b[i*W +: W] = br[i];
    end
    mult_done = 1'b0;
    mult_product = 16'($urandom);
    if (op_on && cyc == done_c) begin
      mult_done = 1'b1; mult_product = stub_prod;
    end else if (cyc == late_c) mult_done = 1'b1;
    else if (cyc >= next_free && $urandom_range(0, 7) == 0) mult_done = 1'b1;
  endtask

  task automatic check_ready();
    int g;
    logic [N-1:0] er;
    er = '0;
    g = (rst || cyc < next_free) ? -1 : exp_grant();
    if (g >= 0) er[g] = 1'b1;
    check("req_ready", req_ready, er);
    hs_id = g;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && req_valid[i]) begin
        glog.push_back(i); hlog.push_back(cyc); hs_seen = cyc;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else if (hs_id >= 0) model_hs(hs_id);
    hs_id = -1;
    #1;
    check_regs();
    drive();
    #1;
    check_ready();
  endtask

  task automatic raise(input int i, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    vr[i] = 1'b1; ar[i] = a; br[i] = b;
  endtask

  task automatic wait_resp();
    int n0, k;
    n0 = resp_cnt; k = 0;
    while (resp_cnt == n0 && k < 60) begin tick(); k++; end
    check("resp_arrived", resp_cnt != n0, 1);
  endtask

  initial begin
    int k, n0;
    for (int i = 0; i < N; i++) begin vr[i] = 1'b0; ar[i] = '0; br[i] = '0; end
    mask = '1; p_raise = 100; rst_req = 1'b1; lat_fix = 9;
    drive();
    tick();
    rst_req = 1'b0;
    k = 0;
    while (glog.size() < 5 && k < 200) begin tick(); k++; end
    for (int i = 0; i < 5; i++) begin
      check("rr_order", (glog.size() > i) ? glog[i] : -1, i % N);
      if (i > 0) check("rr_period",
                       (hlog.size() > i) ? hlog[i] - hlog[i-1] : -1, 12);
    end
    mask = '0; k = 0;
    while ((any_vr() || cyc < next_free) && k < 300) begin tick(); k++; end
    check("drain", any_vr(), 0);

    raise(2, 8'd13, 8'd11);
    wait_resp();
    check("single_grant", glog[$], 2);
    check("single_vec", last_vec, 4'b0100);
    check("single_prod", last_prod, 143);
    check("single_err", last_err, 0);
    check("single_lat", last_resp_c - hs_seen, 11);

    raise(1, 8'd3, 8'd5);
    raise(3, 8'd7, 8'd6);
    wait_resp();
    wait_resp();
    check("wrap_first", glog[$-1], 3);
    check("wrap_second", glog[$], 1);

    lat_fix = 1000;
    raise(0, 8'd7, 8'd9);
    wait_resp();
    check("to_vec", last_vec, 4'b0001);
    check("to_prod", last_prod, 0);
    check("to_err", last_err, 1);
    check("to_lat", last_resp_c - hs_seen, TO + 3);

    lat_fix = TO + 3;
    raise(1, 8'd2, 8'd2);
    wait_resp();
    n0 = resp_cnt;
    for (int i = 0; i < 5; i++) tick();
    check("late_done_ignored", resp_cnt - n0, 0);

    lat_fix = TO + 1;
    raise(2, 8'd200, 8'd250);
    wait_resp();
    check("edge_err", last_err, 0);
    check("edge_prod", last_prod, 50000);
    check("edge_lat", last_resp_c - hs_seen, TO + 3);

    lat_fix = 9;
    n0 = glog.size();
    raise(3, 8'd9, 8'd9);
    k = 0;
    while (glog.size() == n0 && k < 20) begin tick(); k++; end
    check("rst_hs", glog.size() - n0, 1);
    n0 = resp_cnt;
    for (int i = 0; i < 4; i++) tick();
    rst_req = 1'b1;
    tick();
    rst_req = 1'b0;
    tick();
    check("rst_busy", busy, 0);
    for (int i = 0; i < 15; i++) tick();
    check("rst_no_resp", resp_cnt - n0, 0);
    raise(1, 8'd12, 8'd12);
    wait_resp();
    check("post_rst_prod", last_prod, 144);
    check("post_rst_vec", last_vec, 4'b0010);

    mask = '1; p_raise = 30; lat_fix = 0;
    for (int i = 0; i < 3000; i++) begin
      rst_req = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
